// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word read at a time and
// registers each returned word into a valid/ready output slot.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault
);

    typedef enum logic [1:0] {REQ, WAIT, DISCARD, HALT} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        out_valid_q;
    logic [31:0] out_pc_q;
    logic [31:0] out_instr_q;
    logic        out_fault_q;

    logic        free;
    logic        fault_pend;
    logic        accepted;
    logic        outstanding_after;
    logic [31:0] redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_pend_q;
    logic redirect_misaligned;

    assign redirect_target     = redirect_pc;
    assign redirect_misaligned = |redirect_pc[1:0];
    assign fault_pend          = fault_pend_q;
`else
    logic unused_redirect_bits;

    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_bits = ^redirect_pc[1:0];
    assign fault_pend           = 1'b0;
`endif

    // A request is only issued when its response is guaranteed a slot.
    assign free              = !out_valid_q || out_ready;
    assign mem_req_valid     = (state_q == REQ) && free && !fault_pend;
    assign mem_req_addr      = pc_q;
    assign accepted          = mem_req_valid && mem_req_ready;
    assign outstanding_after = (((state_q == WAIT) || (state_q == DISCARD)) && !mem_resp_valid)
                               || accepted;

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign out_fault = out_fault_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'h0000_0000;
            out_instr_q <= 32'h0000_0013;
            out_fault_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_pend_q <= 1'b0;
`endif
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Redirect wins; a still-pending response must be drained in DISCARD.
            if (redirect_valid) begin
                pc_q        <= redirect_target;
                out_valid_q <= 1'b0;
                state_q     <= outstanding_after ? DISCARD : REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
                fault_pend_q <= redirect_misaligned;
`endif
            end else begin
                case (state_q)
                    REQ: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (fault_pend_q) begin
                            if (free) begin
                                out_valid_q  <= 1'b1;
                                out_pc_q     <= pc_q;
                                out_instr_q  <= 32'h0000_0000;
                                out_fault_q  <= 1'b1;
                                fault_pend_q <= 1'b0;
                                state_q      <= HALT;
                            end
                        end else if (accepted) begin
                            state_q <= WAIT;
                        end
`else
                        if (accepted) begin
                            state_q <= WAIT;
                        end
`endif
                    end
                    WAIT: begin
                        if (mem_resp_valid) begin
                            out_valid_q <= 1'b1;
                            out_pc_q    <= pc_q;
                            out_instr_q <= mem_resp_data;
                            out_fault_q <= 1'b0;
                            pc_q        <= pc_q + 32'd4;
                            state_q     <= REQ;
                        end
                    end
                    DISCARD: begin
                        if (mem_resp_valid) begin
                            state_q <= REQ;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a latency-randomized memory model plus a
// transaction-level expectation of the beat stream and request addresses.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        memReqValid;
    logic        memReqReady;
    logic [31:0] memReqAddr;
    logic        memRespValid;
    logic [31:0] memRespData;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        outValid;
    logic        outReady;
    logic [31:0] outPc;
    logic [31:0] outInstr;
    logic        outFault;

    int vectors = 0;
    int miscompares = 0;
    int transfers = 0;

    // Memory model state
    logic        memPending = 1'b0;
    logic [31:0] memAddr = 32'h0;
    int          memCount = 0;

    // Expected-behaviour model state
    logic [31:0] expPc = 32'h0;
    logic [31:0] nextReqAddr = 32'h0;
    logic        reqStale = 1'b0;
    logic        faultExp = 1'b0;
    logic        halted = 1'b0;
    logic [31:0] faultPc = 32'h0;

    // Previous-cycle observations for hold/flush checks
    logic        holdPrev = 1'b0;
    logic        redirPrev = 1'b0;
    logic [31:0] heldPc = 32'h0;
    logic [31:0] heldInstr = 32'h0;
    logic        sValid;

    always #5 clock = ~clock;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_req_valid  (memReqValid),
        .mem_req_ready  (memReqReady),
        .mem_req_addr   (memReqAddr),
        .mem_resp_valid (memRespValid),
        .mem_resp_data  (memRespData),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .out_valid      (outValid),
        .out_ready      (outReady),
        .out_pc         (outPc),
        .out_instr      (outInstr),
        .out_fault      (outFault)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alignPc(input logic [31:0] p);
`ifdef FETCH_MISALIGN_TRAP_EN
        return p;
`else
        return {p[31:2], 2'b00};
`endif
    endfunction

    // One clock cycle: drive at negedge, check #1 later, advance the models at posedge.
    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc,
                                 input int lat, input logic reqRdy);
        logic transfer;
        logic accept;
        @(negedge clock);
        outReady      = rdy;
        redirectValid = redir;
        redirectPc    = rpc;
        memReqReady   = reqRdy;
        memRespValid  = 1'b0;
        memRespData   = 32'h0;
        if (memPending) begin
            if (memCount == 0) begin
                memRespValid = 1'b1;
                memRespData  = memAddr ^ 32'hA5A5_0000;
            end else begin
                memCount--;
            end
        end
        #1;
        sValid = outValid;
        if (holdPrev) begin
            checkOutput("hold_valid", outValid, 1);
            checkOutput("hold_pc", outPc, heldPc);
            checkOutput("hold_instr", outInstr, heldInstr);
        end
        if (redirPrev) begin
            checkOutput("flush_valid", outValid, 0);
        end
        if (faultExp || halted) begin
            checkOutput("halt_no_req", memReqValid, 0);
        end
        accept = memReqValid && reqRdy;
        if (accept) begin
            checkOutput("one_outstanding", memPending, 0);
            checkOutput("req_addr", memReqAddr, nextReqAddr);
        end
        transfer = outValid && rdy;
        if (transfer) begin
            transfers++;
            if (faultExp) begin
                checkOutput("fault_flag", outFault, 1);
                checkOutput("fault_pc", outPc, faultPc);
                checkOutput("fault_instr", outInstr, 0);
                faultExp = 1'b0;
                halted   = 1'b1;
            end else begin
                checkOutput("beat_fault", outFault, 0);
                checkOutput("beat_pc", outPc, expPc);
                checkOutput("beat_instr", outInstr, expPc ^ 32'hA5A5_0000);
                expPc = expPc + 32'd4;
            end
        end
        holdPrev  = outValid && !rdy && !redir;
        heldPc    = outPc;
        heldInstr = outInstr;
        redirPrev = redir;
        @(posedge clock);
        if (memRespValid) begin
            memPending = 1'b0;
            if (!reqStale && !redir) nextReqAddr = nextReqAddr + 32'd4;
        end
        if (accept) begin
            memPending = 1'b1;
            memAddr    = memReqAddr;
            memCount   = lat - 1;
            reqStale   = 1'b0;
        end
        if (redir) begin
            faultExp = 1'b0;
            halted   = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc[1:0] != 2'b00) begin
                faultExp = 1'b1;
                faultPc  = rpc;
            end
`endif
            expPc       = alignPc(rpc);
            nextReqAddr = alignPc(rpc);
            reqStale    = 1'b1;
        end
    endtask

    initial begin
        int startTransfers;
        logic [31:0] rpc;
        reset         = 1'b0;
        outReady      = 1'b1;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        memReqReady   = 1'b1;
        memRespValid  = 1'b0;
        memRespData   = 32'h0;

        repeat (3) @(negedge clock);
        #1;
        checkOutput("reset_req_valid", memReqValid, 1);
        checkOutput("reset_req_addr", memReqAddr, 32'h0);
        checkOutput("reset_out_valid", outValid, 0);
        checkOutput("reset_out_pc", outPc, 32'h0);
        checkOutput("reset_out_instr", outInstr, 32'h0000_0013);
        checkOutput("reset_out_fault", outFault, 0);

        @(posedge clock);
        #1 reset = 1'b1;

        // 1-cycle memory, always ready: a beat after every even edge.
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1, 1'b1);
            checkOutput("first_beat_timing", sValid, ((k - 1) >= 2) && ((k - 1) % 2 == 0));
        end

        // Wrap past the top of the address space.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC, 1, 1'b1);
        startTransfers = transfers;
        repeat (12) applyStimulus(1'b1, 1'b0, 32'h0, 1, 1'b1);
        checkOutput("wrap_beats", (transfers - startTransfers) >= 4, 1);

`ifdef FETCH_MISALIGN_TRAP_EN
        applyStimulus(1'b1, 1'b1, 32'h0000_0102, 1, 1'b1);
        repeat (10) applyStimulus(1'b1, 1'b0, 32'h0, 1, 1'b1);
        checkOutput("trap_halted", halted, 1);
        applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1, 1'b1);
`endif

        startTransfers = transfers;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: rpc = $urandom_range(0, 1023);
            endcase
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc,
                          $urandom_range(1, 3), $urandom_range(0, 3) != 0);
        end
        checkOutput("liveness", (transfers - startTransfers) > 100, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
